// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - shared types and helpers for the iterative fixed-point MAC
package fixed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mac_state_t;

  // Total word width of an INT_W.FRAC_W fixed-point number
  function automatic int calc_w(input int int_w, input int frac_w);
    return int_w + frac_w;
  endfunction

  // High when an overflowing result must be clamped to all-ones
  function automatic logic sat_select(input logic ovf, input bit sat_en);
    return ovf & sat_en;
  endfunction

endpackage

// File: rtl/fixed_shift_add_core.sv
// rtl/fixed_shift_add_core.sv - W-cycle LSB-first shift-add multiplier core
module fixed_shift_add_core #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  logic [2*W-1:0] a_sh;
  logic [2*W-1:0] prod_q;
  logic [W-1:0]   b_sh;
  logic [CNT_W-1:0] cnt;
  logic           running;

  // product is the running sum including the current step, so the final
  // value is available on the same cycle done is asserted
  assign product = prod_q + (b_sh[0] ? a_sh : '0);
  assign done    = running && (cnt == CNT_W'(W - 1));

  // a_sh holds num1 << cnt and b_sh holds num2 >> cnt, avoiding barrel shifters
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      prod_q  <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      prod_q  <= '0;
      a_sh    <= {{W{1'b0}}, a};
      b_sh    <= b;
    end else if (running) begin
      prod_q <= product;
      a_sh   <= a_sh << 1;
      b_sh   <= b_sh >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fixed_mac_iter.sv
// rtl/fixed_mac_iter.sv - iterative unsigned fixed-point multiply-accumulate unit
module fixed_mac_iter
  import fixed_pkg::*;
#(
  parameter int  INT_W    = 8,
  parameter int  FRAC_W   = 8,
  parameter bit  SATURATE = 1'b1,
  localparam int W        = calc_w(INT_W, FRAC_W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] num1,
  input  logic [W-1:0] num2,
  input  logic         acc_en,
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         busy
);

  mac_state_t     state;
  logic [W-1:0]   acc;
  logic           acc_en_q;
  logic           clear_q;
  logic           start;
  logic           core_done;
  logic [2*W-1:0] prod;

  logic [W-1:0]   p;
  logic           ovf_m;
  logic [W-1:0]   acc_base;
  logic [W:0]     sum;
  logic [W-1:0]   raw;
  logic           ovf_next;
  logic [W-1:0]   res_next;
  logic           unused_frac;

  assign in_ready    = (state == IDLE) && !rst;
  assign start       = in_valid && in_ready;
  assign unused_frac = ^prod[FRAC_W-1:0];

  fixed_shift_add_core #(
    .W(W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (num1),
    .b       (num2),
    .done    (core_done),
    .product (prod)
  );

  // Rescale the raw product, optionally accumulate, then apply overflow policy
  always_comb begin
    p        = prod[W+FRAC_W-1:FRAC_W];
    ovf_m    = |prod[2*W-1:W+FRAC_W];
    acc_base = clear_q ? '0 : acc;
    sum      = {1'b0, acc_base} + {1'b0, p};
    if (acc_en_q) begin
      ovf_next = ovf_m | sum[W];
      raw      = sum[W-1:0];
    end else begin
      ovf_next = ovf_m;
      raw      = p;
    end
    res_next = sat_select(ovf_next, SATURATE) ? '1 : raw;
  end

  // Control FSM: accept operands, wait for the core, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      acc_en_q  <= 1'b0;
      clear_q   <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc_en_q <= acc_en;
            clear_q  <= clear;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          if (core_done) begin
            result    <= res_next;
            overflow  <= ovf_next;
            out_valid <= 1'b1;
            if (acc_en_q) begin
              acc <= res_next;
            end else if (clear_q) begin
              acc <= '0;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
